fir_tap_buffer: RTL and testbench
=================================

# fir_tap_buffer

Coefficient store for the FIR accelerator: receives the H stream (32-bit words, two 16-bit taps each) after the controller's start, unpacks it into NB_TAPS registers presented in parallel to the datapath, and reports completion through a done flag. The controller waits on that flag before it leaves its tap-loading phase. This block is the consumer of the H source stream and the producer of the tap-buffer flags.

## Interface
- NB_TAPS, 50: number of 16-bit taps held; must be ≥ 2.
- TAP_WIDTH, 16: tap width; fixed at 16 (two taps per 32-bit word).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous clear (controller clear); same effect as reset.
- start_i  in  1  one-cycle pulse; begins a load.
- h_valid_i  in  1  H stream valid.
- h_ready_o  out  1  H stream ready.
- h_data_i  in  32  H stream data; [15:0] = tap 2k, [31:16] = tap 2k+1.
- taps_o  out  NB_TAPS×16  parallel tap array, index 0 = first tap in memory order.
- done_o  out  1  one-cycle pulse when the last tap is written.
- full_o  out  1  level; all taps valid since the last start.

## Operation
- NWORDS = ceil(NB_TAPS/2); word counter of width $clog2(NWORDS+1).
- States: IDLE, LOAD, FULL.
- IDLE: h_ready_o=0. start_i → LOAD, word counter ← 0, full_o ← 0.
- LOAD: h_ready_o=1. Each handshake (h_valid_i & h_ready_o) writes taps[2k]←h_data_i[15:0], and taps[2k+1]←h_data_i[31:16] if 2k+1 < NB_TAPS; k increments.
- Odd NB_TAPS: upper half of the final word is discarded, not stored anywhere.
- Handshake on word NWORDS-1 → FULL; done_o=1 for that transition cycle only (registered, see Timing).
- FULL: h_ready_o=0; extra H words stall and are never consumed. full_o=1. start_i → LOAD (reload; old taps remain on taps_o until overwritten word by word; full_o drops).
- start_i in LOAD: counter restarts at 0; partial load abandoned; no done_o.
- start_i and final handshake in the same cycle: the handshake data is written, start wins → LOAD with counter 0, done_o not asserted.
- rst_i or clear_i: state IDLE, counter 0, all taps 0, done_o=0, full_o=0, h_ready_o=0. clear_i takes priority over start_i and handshakes.
- No arithmetic on tap values; data stored bit-exact.

## Timing
- Reset values: h_ready_o=0, done_o=0, full_o=0, taps_o=all zero.
- start_i at cycle t → h_ready_o=1 at t+1 (registered state, combinational ready from state).
- Throughput 1 word/cycle; writes visible on taps_o the cycle after the handshake.
- Final handshake at cycle t → done_o=1 and full_o=1 at t+1; done_o=0 at t+2.
- Minimum load latency start→done: NWORDS+1 cycles with h_valid_i held high.
- h_ready_o never depends combinationally on h_valid_i.

## Configuration
- FIR_TAP_BUFFER_REVERSE_EN defined: tap j from memory (j = 2k or 2k+1) is stored at taps_o index NB_TAPS-1-j, so index 0 holds the last tap (direct-form ordering for the MAC chain). Odd-NB_TAPS discard rule unchanged.
- Not defined: tap j stored at index j.

## Test plan
- NB_TAPS=50, start, 25 words 0x{2k+1}{2k} back-to-back → done_o pulse exactly at cycle start+26, taps_o[j]=j for all j, full_o=1.
- NB_TAPS=5, 3 words, last word 0xDEAD0004 → taps_o[4]=0x0004, 0xDEAD absent from every tap, done_o after 3rd handshake.
- Random h_valid_i gaps (50% duty), then 4 extra words in FULL → taps correct, h_ready_o=0 in FULL, extra words not consumed.
- start_i re-asserted after 10 of 25 words → no done_o, counter restarts, next 25 words load fully, single done_o.
- clear_i mid-load (word 12) and rst_i mid-load → taps all zero, IDLE, h_ready_o=0 next cycle; subsequent start loads normally.
- With FIR_TAP_BUFFER_REVERSE_EN, NB_TAPS=50, words as in first test → taps_o[49-j]=j.

Source files
------------

// File: rtl/fir_tap_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_buffer
// Description : FIR coefficient store. Unpacks the 32-bit H stream (two taps
//               per word) into NB_TAPS parallel tap registers and flags when
//               the load has completed. The optional macro
//               FIR_TAP_BUFFER_REVERSE_EN stores the taps in reverse order.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_buffer #(
  parameter int NB_TAPS   = 50,
  parameter int TAP_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                start_i,
  input  logic                                h_valid_i,
  output logic                                h_ready_o,
  input  logic [2*TAP_WIDTH-1:0]              h_data_i,
  output logic [NB_TAPS-1:0][TAP_WIDTH-1:0]   taps_o,
  output logic                                done_o,
  output logic                                full_o
);

  localparam int              c_nwords    = (NB_TAPS + 1) / 2;
  localparam int              c_cnt_w     = $clog2(c_nwords + 1);
  localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(c_nwords - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_hs;
  logic                 w_last;

  // Ready comes from state only, never from h_valid_i.
  assign h_ready_o = (r_state == ST_LOAD);
  assign w_hs      = h_valid_i & h_ready_o;
  assign w_last    = (r_cnt == c_last_word);
  assign done_o    = r_done;
  assign full_o    = (r_state == ST_FULL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
          end
        end
        ST_LOAD: begin
          // A restart abandons the partial load even on the final word.
          if (start_i) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
          end else if (w_hs) begin
            if (w_last) begin
              w_state_nxt = ST_FULL;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
          end
        end
        ST_FULL: begin
          if (start_i) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Each output slot knows statically which memory tap it holds, so a write
  // is just a compare of the word counter against that tap's word index.
  // With odd NB_TAPS no slot maps to the upper half of the final word.
  for (genvar gi = 0; gi < NB_TAPS; gi++) begin : g_tap
`ifdef FIR_TAP_BUFFER_REVERSE_EN
    localparam int c_mem_idx = NB_TAPS - 1 - gi;
`else
    localparam int c_mem_idx = gi;
`endif
    localparam logic [c_cnt_w-1:0] c_word = c_cnt_w'(c_mem_idx / 2);
    localparam bit                 c_hi   = ((c_mem_idx % 2) == 1);

    logic [TAP_WIDTH-1:0] r_tap;
    logic [TAP_WIDTH-1:0] w_src;

    assign w_src = c_hi ? h_data_i[2*TAP_WIDTH-1:TAP_WIDTH] : h_data_i[TAP_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_tap <= '0;
      end else if (clear_i) begin
        r_tap <= '0;
      end else if (w_hs && (r_cnt == c_word)) begin
        r_tap <= w_src;
      end
    end

    assign taps_o[gi] = r_tap;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_tap_buffer
// Description : Self-checking bench for fir_tap_buffer (NB_TAPS=50 and 5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tap_buffer;

  localparam int N  = 50;
  localparam int NW = 25;
  localparam int N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, clr, valid, ready, done, full;
  logic [31:0] data;
  logic [N-1:0][15:0] taps;
  logic start5, clr5, valid5, ready5, done5, full5;
  logic [31:0] data5;
  logic [N5-1:0][15:0] taps5;

  fir_tap_buffer #(.NB_TAPS(N), .TAP_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start),
    .h_valid_i(valid), .h_ready_o(ready), .h_data_i(data),
    .taps_o(taps), .done_o(done), .full_o(full)
  );

  fir_tap_buffer #(.NB_TAPS(N5), .TAP_WIDTH(16)) dut5 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr5), .start_i(start5),
    .h_valid_i(valid5), .h_ready_o(ready5), .h_data_i(data5),
    .taps_o(taps5), .done_o(done5), .full_o(full5)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int map_idx(int j, int n);
`ifdef FIR_TAP_BUFFER_REVERSE_EN
    return n - 1 - j;
`else
    return j;
`endif
  endfunction

  function automatic logic [31:0] word(int k);
    return {16'(2 * k + 1), 16'(2 * k)};
  endfunction

  // Reference model: loading flag, words taken, expected taps.
  bit          m_load, m_full, m_done;
  int          m_taken;
  logic [15:0] m_taps [N];
  int          ncyc, ndone, t_done;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_taps[i] = '0;
    m_load = 0; m_full = 0; m_done = 0; m_taken = 0;
  endtask

  task automatic compare50(string tag);
    int bad;
    bad = -1;
    chk({tag, "_ready"}, ready, m_load);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_full"}, full, m_full);
    for (int i = N - 1; i >= 0; i--) if (taps[i] !== m_taps[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_taps index=%0d actual=%0h required=%0h", tag, bad, taps[bad], m_taps[bad]);
    end
  endtask

  task automatic cyc(string tag, bit s, bit c, bit v, logic [31:0] d);
    bit acc;
    start = s; clr = c; valid = v; data = d;
    @(posedge clk);
    acc = m_load && v;
    if (c) begin
      model_reset();
    end else begin
      m_done = 0;
      if (acc) begin
        m_taps[map_idx(2 * m_taken, N)] = d[15:0];
        if (2 * m_taken + 1 < N) m_taps[map_idx(2 * m_taken + 1, N)] = d[31:16];
        m_taken++;
      end
      if (s) begin
        m_load = 1; m_taken = 0; m_full = 0;
      end else if (acc && m_taken == NW) begin
        m_load = 0; m_full = 1; m_done = 1;
      end
    end
    #1;
    ncyc++;
    if (done === 1'b1) begin
      ndone++;
      t_done = ncyc;
    end
    compare50(tag);
  endtask

  typedef struct {
    bit          s;
    bit          v;
    logic [31:0] d;
    bit          er;
    bit          ed;
    bit          ef;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int t_start, nd0, budget, hits;
    rst = 1; start = 0; clr = 0; valid = 0; data = '0;
    start5 = 0; clr5 = 0; valid5 = 0; data5 = '0;
    ncyc = 0; ndone = 0; t_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare50("reset");
    chk("reset5_ready", ready5, 0);
    chk("reset5_done", done5, 0);
    chk("reset5_full", full5, 0);
    chk("reset5_taps", taps5, '0);
    rst = 0;

    // NB_TAPS=5: odd tap count, upper half of the last word dropped.
    tbl[0] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0001_0000,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0003_0002,  1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'hDEAD_0004,  1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'hBEEF_0007,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h1111_2222,  1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      start5 = tbl[i].s; valid5 = tbl[i].v; data5 = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("n5_ready_%0d", i), ready5, tbl[i].er);
      chk($sformatf("n5_done_%0d", i), done5, tbl[i].ed);
      chk($sformatf("n5_full_%0d", i), full5, tbl[i].ef);
    end
    start5 = 0; valid5 = 0;
    for (int j = 0; j < N5; j++) chk($sformatf("n5_tap_%0d", j), taps5[map_idx(j, N5)], j);
    hits = 0;
    for (int i = 0; i < N5; i++) if (taps5[i] == 16'hDEAD) hits++;
    chk("n5_dead_absent", hits, 0);

    // Back-to-back full load.
    cyc("start", 1, 0, 0, 0);
    t_start = ncyc;
    nd0 = ndone;
    for (int k = 0; k < NW; k++) cyc("b2b", 0, 0, 1, word(k));
    chk("b2b_latency", t_done - t_start + 1, NW + 1);
    for (int j = 0; j < N; j++) if (taps[map_idx(j, N)] !== 16'(j)) chk($sformatf("b2b_tap_%0d", j), taps[map_idx(j, N)], j);
    cyc("b2b_after", 0, 0, 0, 0);
    chk("b2b_one_done", ndone - nd0, 1);

    // Random valid gaps, then extra words offered while full.
    cyc("rstart", 1, 0, 0, 0);
    budget = 0;
    while (!m_full && budget < 400) begin
      cyc("rand", 0, 0, 1'($urandom_range(0, 1)), $urandom);
      budget++;
    end
    chk("rand_full", full, 1);
    for (int i = 0; i < 4; i++) cyc("extra", 0, 0, 1, $urandom);

    // Restart after 10 words, then a full load: one done only.
    nd0 = ndone;
    cyc("rl_start", 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc("rl_part", 0, 0, 1, $urandom);
    cyc("rl_restart", 1, 0, 1, $urandom);
    for (int k = 0; k < NW; k++) cyc("rl_full", 0, 0, 1, word(k + 7));
    cyc("rl_idle", 0, 0, 0, 0);
    chk("rl_single_done", ndone - nd0, 1);

    // Start coincident with the final handshake: start wins.
    nd0 = ndone;
    cyc("co_start", 1, 0, 0, 0);
    for (int k = 0; k < NW - 1; k++) cyc("co_load", 0, 0, 1, $urandom);
    cyc("co_last", 1, 0, 1, 32'hA5A5_5A5A);
    chk("co_no_done", ndone - nd0, 0);
    for (int k = 0; k < NW; k++) cyc("co_reload", 0, 0, 1, word(k));
    cyc("co_idle", 0, 0, 0, 0);
    chk("co_one_done", ndone - nd0, 1);

    // Clear mid-load, clear beating start, then a normal load.
    cyc("cl_start", 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) cyc("cl_load", 0, 0, 1, $urandom);
    cyc("cl_clear", 0, 1, 1, $urandom);
    chk("cl_zero", taps, '0);
    cyc("cl_vs_start", 1, 1, 1, $urandom);
    cyc("cl_idle", 0, 0, 1, $urandom);
    cyc("cl_start2", 1, 0, 0, 0);
    for (int k = 0; k < NW; k++) cyc("cl_reload", 0, 0, 1, $urandom);

    // Asynchronous reset mid-load.
    cyc("ar_start", 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc("ar_load", 0, 0, 1, $urandom);
    #2 rst = 1;
    #1;
    model_reset();
    compare50("async_rst");
    @(posedge clk);
    #1 rst = 0;
    cyc("ar_idle", 0, 0, 1, $urandom);
    cyc("ar_start2", 1, 0, 0, 0);
    for (int k = 0; k < NW; k++) cyc("ar_reload", 0, 0, 1, word(k));
    chk("ar_full", full, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
